// File: rtl/recirc_pkg.sv
// Shared definitions for the lane recirculator: FSM state encoding and the
// pointer-width helper used to size each lane's replay FIFO.
package recirc_pkg;

  typedef enum logic [1:0] {
    ST_FWD    = 2'd0,
    ST_RECIRC = 2'd1,
    ST_REPLAY = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/recirc_lane_fifo.sv
// Per-lane replay FIFO. Pointers carry one extra wrap bit so full and empty
// are distinguishable; a pop and a push in the same cycle at full are both taken.
module recirc_lane_fifo
  import recirc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_head,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_empty_next
);

  localparam int AW = clog2(DEPTH);

  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_pop;
  logic             w_do_push;
  logic [AW:0]      w_wr_next;
  logic [AW:0]      w_rd_next;

  assign o_empty      = (r_wr == r_rd);
  assign o_full       = ((r_wr - r_rd) == (AW+1)'(DEPTH));
  assign o_head       = r_mem[r_rd[AW-1:0]];
  assign w_do_pop     = i_pop & ~o_empty;
  assign w_do_push    = i_push & (~o_full | w_do_pop);
  assign w_wr_next    = r_wr + (AW+1)'(w_do_push);
  assign w_rd_next    = r_rd + (AW+1)'(w_do_pop);
  assign o_empty_next = (w_wr_next == w_rd_next);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      r_wr <= w_wr_next;
      r_rd <= w_rd_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_reset) r_mem[r_wr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/recirc_lanes_buf.sv
// N-lane recirculator between the byte sources and the serialiser.
// Optional per-lane statistics counters are enabled with `define RECIRC_STATS_EN.
module recirc_lanes_buf
  import recirc_pkg::*;
#(
  parameter int LANES = 4,
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk_f,
  input  logic                   reset,
  input  logic                   active_serial,
  input  logic [LANES*WIDTH-1:0] data_in,
  input  logic [LANES-1:0]       valid_in,
  output logic [LANES*WIDTH-1:0] data_out,
  output logic [LANES-1:0]       valid_out,
  output logic [LANES*WIDTH-1:0] recirc_data,
  output logic [LANES-1:0]       recirc_valid,
  output logic                   replaying,
  output logic [LANES-1:0]       overflow,
`ifdef RECIRC_STATS_EN
  output logic [LANES*16-1:0]    fwd_count,
  output logic [LANES*8-1:0]     drop_count,
`endif
  output logic [1:0]             dbg_state
);

  localparam int LW = LANES * WIDTH;

  state_e           r_state;
  state_e           w_state_next;
  logic [LANES-1:0] w_empty;
  logic [LANES-1:0] w_full;
  logic [LANES-1:0] w_empty_next;
  logic [LANES-1:0] w_push;
  logic [LANES-1:0] w_pop;
  logic [LANES-1:0] w_vout;
  logic [LANES-1:0] w_rvalid;
  logic [LANES-1:0] w_drop;
  logic [LW-1:0]    w_head;
  logic [LW-1:0]    w_dout;
  logic [LW-1:0]    w_rdata;

  // Datapath depends only on active_serial and buffer occupancy: a non-empty
  // lane always drains before live words, an empty lane passes straight through.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign w_pop[g]    = active_serial & ~w_empty[g];
    assign w_push[g]   = valid_in[g] & (~active_serial | ~w_empty[g]);
    assign w_drop[g]   = valid_in[g] & ~active_serial & w_full[g];
    assign w_vout[g]   = active_serial & (~w_empty[g] | valid_in[g]);
    assign w_rvalid[g] = ~active_serial & valid_in[g];
    assign w_dout[g*WIDTH +: WIDTH]  = !w_vout[g]  ? '0 :
                                       !w_empty[g] ? w_head[g*WIDTH +: WIDTH] :
                                                     data_in[g*WIDTH +: WIDTH];
    assign w_rdata[g*WIDTH +: WIDTH] = w_rvalid[g] ? data_in[g*WIDTH +: WIDTH] : '0;

    recirc_lane_fifo #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
    ) u_fifo (
      .i_clk        (clk_f),
      .i_reset      (reset),
      .i_push       (w_push[g]),
      .i_pop        (w_pop[g]),
      .i_data       (data_in[g*WIDTH +: WIDTH]),
      .o_head       (w_head[g*WIDTH +: WIDTH]),
      .o_empty      (w_empty[g]),
      .o_full       (w_full[g]),
      .o_empty_next (w_empty_next[g])
    );
  end

  // Same rule from every state: inactive recirculates, otherwise replay until drained.
  always_comb begin
    w_state_next = r_state;
    if (!active_serial)      w_state_next = ST_RECIRC;
    else if (&w_empty_next)  w_state_next = ST_FWD;
    else                     w_state_next = ST_REPLAY;
  end

  always_ff @(posedge clk_f) begin
    if (reset) begin
      r_state      <= ST_FWD;
      data_out     <= '0;
      valid_out    <= '0;
      recirc_data  <= '0;
      recirc_valid <= '0;
      overflow     <= '0;
    end else begin
      r_state      <= w_state_next;
      data_out     <= w_dout;
      valid_out    <= w_vout;
      recirc_data  <= w_rdata;
      recirc_valid <= w_rvalid;
      overflow     <= overflow | w_drop;
    end
  end

  assign replaying = (r_state == ST_REPLAY);
  assign dbg_state = r_state;

`ifdef RECIRC_STATS_EN
  for (genvar g = 0; g < LANES; g++) begin : g_stats
    logic [15:0] r_fwd;
    logic [7:0]  r_drop;

    always_ff @(posedge clk_f) begin
      if (reset) begin
        r_fwd  <= '0;
        r_drop <= '0;
      end else begin
        if (w_vout[g] && r_fwd != 16'hFFFF) r_fwd <= r_fwd + 16'd1;
        if (w_drop[g] && r_drop != 8'hFF)   r_drop <= r_drop + 8'd1;
      end
    end

    assign fwd_count[g*16 +: 16] = r_fwd;
    assign drop_count[g*8 +: 8]  = r_drop;
  end
`endif

endmodule

// File: tb/tb_recirc_lanes_buf.sv
// Bench for recirc_lanes_buf: queue-based lane model feeds an expected queue,
// a negedge monitor pops and compares every registered output.
module tb_recirc_lanes_buf;

  localparam int LANES = 4;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int LW    = LANES * WIDTH;

  logic             clk_f = 1'b0;
  logic             reset;
  logic             active_serial;
  logic [LW-1:0]    data_in;
  logic [LANES-1:0] valid_in;
  logic [LW-1:0]    data_out;
  logic [LANES-1:0] valid_out;
  logic [LW-1:0]    recirc_data;
  logic [LANES-1:0] recirc_valid;
  logic             replaying;
  logic [LANES-1:0] overflow;
  logic [1:0]       dbg_state;
`ifdef RECIRC_STATS_EN
  logic [LANES*16-1:0] fwd_count;
  logic [LANES*8-1:0]  drop_count;
`endif

  recirc_lanes_buf #(
    .LANES(LANES),
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk_f        (clk_f),
    .reset        (reset),
    .active_serial(active_serial),
    .data_in      (data_in),
    .valid_in     (valid_in),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .recirc_data  (recirc_data),
    .recirc_valid (recirc_valid),
    .replaying    (replaying),
    .overflow     (overflow),
`ifdef RECIRC_STATS_EN
    .fwd_count    (fwd_count),
    .drop_count   (drop_count),
`endif
    .dbg_state    (dbg_state)
  );

  // clock / reset
  always #5 clk_f = ~clk_f;

  typedef struct packed {
    logic [LW-1:0]       dout;
    logic [LANES-1:0]    vout;
    logic [LW-1:0]       rdata;
    logic [LANES-1:0]    rvalid;
    logic                repl;
    logic [LANES-1:0]    ovf;
    logic [1:0]          st;
    logic [LANES*16-1:0] fwdc;
    logic [LANES*8-1:0]  dropc;
  } exp_t;

  exp_t             exp_q[$];
  exp_t             mon_e;
  logic [WIDTH-1:0] mq[LANES][$];
  logic [LANES-1:0] m_ovf;
  int               m_fwd[LANES];
  int               m_drop[LANES];
  int               n_cmp = 0;
  int               n_err = 0;

  function automatic logic [LW-1:0] lane_mask(input logic [LANES-1:0] v);
    logic [LW-1:0] m;
    m = '0;
    for (int i = 0; i < LANES; i++) m[i*WIDTH +: WIDTH] = {WIDTH{v[i]}};
    return m;
  endfunction

  function automatic logic [LW-1:0] lane_word(input int lane, input int val);
    logic [LW-1:0] d;
    d = '0;
    d[lane*WIDTH +: WIDTH] = WIDTH'(val);
    return d;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // driver: apply one cycle of stimulus and push the model's expected response
  task automatic drive(input logic rst, input logic act, input logic [LANES-1:0] vin,
                       input logic [LW-1:0] din);
    exp_t             e;
    logic [WIDTH-1:0] w;
    int               busy;
    @(negedge clk_f);
    #1;
    reset         = rst;
    active_serial = act;
    valid_in      = vin;
    data_in       = din;
    e = '0;
    if (rst) begin
      for (int i = 0; i < LANES; i++) begin
        mq[i].delete();
        m_fwd[i]  = 0;
        m_drop[i] = 0;
      end
      m_ovf = '0;
    end else begin
      busy = 0;
      for (int i = 0; i < LANES; i++) begin
        w = din[i*WIDTH +: WIDTH];
        if (!act) begin
          if (vin[i]) begin
            e.rvalid[i] = 1'b1;
            e.rdata[i*WIDTH +: WIDTH] = w;
            if (mq[i].size() < DEPTH) mq[i].push_back(w);
            else begin
              m_ovf[i] = 1'b1;
              if (m_drop[i] < 255) m_drop[i]++;
            end
          end
        end else if (mq[i].size() > 0) begin
          e.vout[i] = 1'b1;
          e.dout[i*WIDTH +: WIDTH] = mq[i].pop_front();
          if (vin[i]) mq[i].push_back(w);
        end else if (vin[i]) begin
          e.vout[i] = 1'b1;
          e.dout[i*WIDTH +: WIDTH] = w;
        end
        if (e.vout[i] && m_fwd[i] < 65535) m_fwd[i]++;
        if (mq[i].size() > 0) busy = 1;
        e.fwdc[i*16 +: 16] = 16'(m_fwd[i]);
        e.dropc[i*8 +: 8]  = 8'(m_drop[i]);
      end
      e.ovf  = m_ovf;
      e.st   = !act ? 2'd1 : (busy != 0 ? 2'd2 : 2'd0);
      e.repl = (e.st == 2'd2);
    end
    exp_q.push_back(e);
  endtask

  // monitor / scoreboard
  always @(negedge clk_f) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("valid_out", 64'(valid_out), 64'(mon_e.vout));
      check("data_out", 64'(data_out & lane_mask(mon_e.vout)), 64'(mon_e.dout));
      check("recirc_valid", 64'(recirc_valid), 64'(mon_e.rvalid));
      check("recirc_data", 64'(recirc_data & lane_mask(mon_e.rvalid)), 64'(mon_e.rdata));
      check("replaying", 64'(replaying), 64'(mon_e.repl));
      check("overflow", 64'(overflow), 64'(mon_e.ovf));
      check("state", 64'(dbg_state), 64'(mon_e.st));
`ifdef RECIRC_STATS_EN
      check("fwd_count", 64'(fwd_count), 64'(mon_e.fwdc));
      check("drop_count", 64'(drop_count), 64'(mon_e.dropc));
`endif
    end
  end

  initial begin
    reset         = 1'b1;
    active_serial = 1'b1;
    valid_in      = '0;
    data_in       = '0;

    // reset held two cycles with all lanes valid
    drive(1'b1, 1'b1, 4'hF, LW'($urandom));
    drive(1'b1, 1'b1, 4'hF, LW'($urandom));

    // plain forwarding of edge-value bytes
    drive(1'b0, 1'b1, 4'hF, 32'hFDFF01EE);

    // short inactive window on lane 0, then replay ahead of live words
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 4'h1, lane_word(0, 8'hEF + k));
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b1, 4'h1, lane_word(0, 8'hF2 + k));
    repeat (6) drive(1'b0, 1'b1, 4'h0, '0);

    // overflow on lane 2: DEPTH+2 words while inactive
    for (int k = 0; k < DEPTH + 2; k++) drive(1'b0, 1'b0, 4'h4, lane_word(2, 8'h30 + k));
    repeat (DEPTH + 3) drive(1'b0, 1'b1, 4'h0, '0);

    // serialiser drops out mid-replay on lane 1
    for (int k = 0; k < 5; k++) drive(1'b0, 1'b0, 4'h2, lane_word(1, 8'h50 + k));
    repeat (2) drive(1'b0, 1'b1, 4'h0, '0);
    for (int k = 0; k < 2; k++) drive(1'b0, 1'b0, 4'h2, lane_word(1, 8'h60 + k));
    repeat (8) drive(1'b0, 1'b1, 4'h0, '0);

    // randomised traffic with frequent inactive windows
    for (int k = 0; k < 400; k++)
      drive(1'b0, ($urandom_range(0, 3) != 0), LANES'($urandom), LW'($urandom));
    repeat (DEPTH + 2) drive(1'b0, 1'b1, 4'h0, '0);

    // reset clears sticky overflow, then 300 forwarded words on lane 3
    drive(1'b1, 1'b1, 4'h0, '0);
    for (int k = 0; k < 300; k++) drive(1'b0, 1'b1, 4'h8, LW'($urandom));

    // overflow on lane 2 again after a reset, drained by replay
    for (int k = 0; k < DEPTH + 2; k++) drive(1'b0, 1'b0, 4'h4, lane_word(2, 8'hA0 + k));
    repeat (DEPTH + 3) drive(1'b0, 1'b1, 4'h0, '0);
    drive(1'b1, 1'b1, 4'h0, '0);
    repeat (2) drive(1'b0, 1'b1, 4'h0, '0);

    // let the monitor drain, bounded
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk_f);
    @(negedge clk_f);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
